// File: rtl/gate_tt_sequencer_if.sv
// Lane bus between the truth-table sequencer (master) and the gate datapath (slave).
interface gate_tt_sequencer_if;
  logic x1;
  logic x2;
  logic y2;
  logic x3;
  logic y3;
  logic z1;
  logic z2;
  logic z3;

  modport master (output x1, x2, y2, x3, y3, input z1, z2, z3);
  modport slave  (input x1, x2, y2, x3, y3, output z1, z2, z3);
endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for buffer/XNOR/NAND lanes: 10 vectors of SETTLE_CYC+3 cycles, done one cycle later; start ignored while busy, abort any time.
// Define GATE_TT_FAULT_LOG_EN to add the first-mismatch log ports (ff_valid, ff_gate, ff_vec, ff_obs).
module gate_tt_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  gate_tt_sequencer_if.master lane,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [1:0]          cur_gate,
  output logic [1:0]          cur_vec
`ifdef GATE_TT_FAULT_LOG_EN
  ,
  output logic                ff_valid,
  output logic [1:0]          ff_gate,
  output logic [1:0]          ff_vec,
  output logic                ff_obs
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [1:0]       gate;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_done;
  logic             x1_q;
  logic             x2_q;
  logic             y2_q;
  logic             x3_q;
  logic             y3_q;
  logic             last_vec;
  logic             last_run;
  logic             obs;
  logic             exp_val;
  logic             mismatch;
  logic             accept;
  logic             kill;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign cur_gate = gate;
  assign cur_vec  = vec;

  assign lane.x1 = x1_q;
  assign lane.x2 = x2_q;
  assign lane.y2 = y2_q;
  assign lane.x3 = x3_q;
  assign lane.y3 = y3_q;

  assign accept      = (state == S_IDLE) && start && !abort;
  assign kill        = (state != S_IDLE) && abort;
  assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
  assign last_vec    = (gate == 2'd0) ? (vec == 2'd1) : (vec == 2'd3);
  assign last_run    = (gate == 2'd2) && (vec == 2'd3);

  // Expected value comes from the registered lane inputs, i.e. what the datapath actually sees.
  always_comb begin
    obs     = 1'b0;
    exp_val = 1'b0;
    case (gate)
      2'd0: begin
        obs     = lane.z1;
        exp_val = x1_q;
      end
      2'd1: begin
        obs     = lane.z2;
        exp_val = ~(x2_q ^ y2_q);
      end
      default: begin
        obs     = lane.z3;
        exp_val = ~(x3_q & y3_q);
      end
    endcase
  end

  assign mismatch = (state == S_CHECK) && (obs != exp_val);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: if (settle_done) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_NEXT;
      S_NEXT:   state_nxt = last_run ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gate       <= 2'd0;
      vec        <= 2'd0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      pass       <= 1'b0;
      x1_q       <= 1'b0;
      x2_q       <= 1'b0;
      y2_q       <= 1'b0;
      x3_q       <= 1'b0;
      y3_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kill) begin
        gate <= 2'd0;
        vec  <= 2'd0;
        pass <= 1'b0;
        x1_q <= 1'b0;
        x2_q <= 1'b0;
        y2_q <= 1'b0;
        x3_q <= 1'b0;
        y3_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              err_cnt <= '0;
              pass    <= 1'b0;
              gate    <= 2'd0;
              vec     <= 2'd0;
            end
          end
          S_DRIVE: begin
            // Lanes not under test are forced to 0.
            x1_q         <= (gate == 2'd0) ? vec[0] : 1'b0;
            {x2_q, y2_q} <= (gate == 2'd1) ? vec : 2'b00;
            {x3_q, y3_q} <= (gate == 2'd2) ? vec : 2'b00;
            settle_cnt   <= '0;
          end
          S_SETTLE: begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
          S_CHECK: begin
            if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
          end
          S_NEXT: begin
            if (last_run) begin
              gate <= 2'd0;
              vec  <= 2'd0;
              pass <= (err_cnt == '0);
            end else if (last_vec) begin
              gate <= gate + 2'd1;
              vec  <= 2'd0;
            end else begin
              vec <= vec + 2'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef GATE_TT_FAULT_LOG_EN
  // Only the first mismatch of a run is kept; the log survives abort and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_gate  <= 2'd0;
      ff_vec   <= 2'd0;
      ff_obs   <= 1'b0;
    end else if (accept) begin
      ff_valid <= 1'b0;
      ff_gate  <= 2'd0;
      ff_vec   <= 2'd0;
      ff_obs   <= 1'b0;
    end else if (mismatch && !abort && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_gate  <= gate;
      ff_vec   <= vec;
      ff_obs   <= obs;
    end
  end
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench: instance A (SETTLE_CYC=2, ERR_W=4) and instance B (SETTLE_CYC=0, ERR_W=2) with faultable datapath models.
module tb_gate_tt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       rst_na, start_a, abort_a;
  logic       rst_nb, start_b, abort_b;
  logic [1:0] fault_a, fault_b;   // 0 good, 1 z3 stuck-at-0, 2 all outputs inverted

  logic       busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [1:0] gate_a, vec_a;
  logic       busy_b, done_b, pass_b;
  logic [1:0] err_b;
  logic [1:0] gate_b, vec_b;

  gate_tt_sequencer_if ifa ();
  gate_tt_sequencer_if ifb ();

  assign ifa.z1 = ifa.x1 ^ (fault_a == 2'd2);
  assign ifa.z2 = ~(ifa.x2 ^ ifa.y2) ^ (fault_a == 2'd2);
  assign ifa.z3 = (fault_a == 2'd1) ? 1'b0 : (~(ifa.x3 & ifa.y3) ^ (fault_a == 2'd2));
  assign ifb.z1 = ifb.x1 ^ (fault_b == 2'd2);
  assign ifb.z2 = ~(ifb.x2 ^ ifb.y2) ^ (fault_b == 2'd2);
  assign ifb.z3 = (fault_b == 2'd1) ? 1'b0 : (~(ifb.x3 & ifb.y3) ^ (fault_b == 2'd2));

`ifdef GATE_TT_FAULT_LOG_EN
  logic       ffv_a, ffo_a, ffv_b, ffo_b;
  logic [1:0] ffg_a, ffvec_a, ffg_b, ffvec_b;
`endif

  gate_tt_sequencer #(.SETTLE_CYC(2), .ERR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_na), .start(start_a), .abort(abort_a), .lane(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .cur_gate(gate_a), .cur_vec(vec_a)
`ifdef GATE_TT_FAULT_LOG_EN
    , .ff_valid(ffv_a), .ff_gate(ffg_a), .ff_vec(ffvec_a), .ff_obs(ffo_a)
`endif
  );

  gate_tt_sequencer #(.SETTLE_CYC(0), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .abort(abort_b), .lane(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .cur_gate(gate_b), .cur_vec(vec_b)
`ifdef GATE_TT_FAULT_LOG_EN
    , .ff_valid(ffv_b), .ff_gate(ffg_b), .ff_vec(ffvec_b), .ff_obs(ffo_b)
`endif
  );

  int gate_tab [10] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int vec_tab  [10] = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3};

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int lanes_a();
    return {27'd0, ifa.x1, ifa.x2, ifa.y2, ifa.x3, ifa.y3};
  endfunction

  function automatic int lanes_b();
    return {27'd0, ifb.x1, ifb.x2, ifb.y2, ifb.x3, ifb.y3};
  endfunction

  // {gate, vec, x1, x2, y2, x3, y3} for table entry k
  function automatic int exp_vec(input int k);
    int g, v, l;
    g = gate_tab[k];
    v = vec_tab[k];
    if (g == 0)      l = (v & 1) << 4;
    else if (g == 1) l = v << 2;
    else             l = v;
    return (g << 7) | (v << 5) | l;
  endfunction

  // Returns at the negedge of cycle 1 (first cycle after the accepting edge).
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // Full run on A with vector-order checks; optional stray start pulses at cycles 5 and 30.
  task automatic run_a(input string tag, input bit repulse);
    int ndone, dcyc;
    ndone = 0;
    dcyc  = -1;
    pulse_start_a();
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (done_a) begin
        ndone++;
        dcyc = c;
      end
      if (c == 50) chk({tag, "_busy50"}, busy_a, 1);
      if (c == 52) chk({tag, "_busy52"}, busy_a, 0);
      if ((c % 5) == 4 && c < 50)
        chk($sformatf("%s_vec%0d", tag, c / 5), (gate_a << 7) | (vec_a << 5) | lanes_a(), exp_vec(c / 5));
      start_a = repulse && (c == 5 || c == 30);
    end
    start_a = 1'b0;
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_donecyc"}, dcyc, 51);
  endtask

  task automatic run_b(input string tag, input int want_err, input int want_pass);
    int ndone, dcyc;
    ndone = 0;
    dcyc  = -1;
    pulse_start_b();
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (done_b) begin
        ndone++;
        dcyc = c;
        chk({tag, "_pass_at_done"}, pass_b, want_pass);
      end
    end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_donecyc"}, dcyc, 31);
    chk({tag, "_err"}, err_b, want_err);
    chk({tag, "_pass"}, pass_b, want_pass);
  endtask

  initial begin
    int ndone;
    rst_na = 1'b0; start_a = 1'b0; abort_a = 1'b0; fault_a = 2'd0;
    rst_nb = 1'b0; start_b = 1'b0; abort_b = 1'b0; fault_b = 2'd0;
    repeat (3) @(negedge clk);

    chk("rst_a_ctl", {busy_a, done_a, pass_a}, 0);
    chk("rst_a_err", err_a, 0);
    chk("rst_a_cur", {gate_a, vec_a}, 0);
    chk("rst_a_lanes", lanes_a(), 0);
    chk("rst_b_all", {busy_b, done_b, pass_b, err_b, gate_b, vec_b}, 0);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    @(negedge clk);

    // Good datapath, default timing
    run_a("good", 1'b0);
    chk("good_err", err_a, 0);
    chk("good_pass", pass_a, 1);
    chk("good_hold_lanes", lanes_a(), 5'b00011);
    chk("good_idle_cur", {gate_a, vec_a}, 0);

    // Stray starts during a run
    run_a("restart", 1'b1);
    chk("restart_pass", pass_a, 1);

    // z3 stuck-at-0: nand vec 0..2 fail
    fault_a = 2'd1;
    run_a("z3sa0", 1'b0);
    chk("z3sa0_err", err_a, 3);
    chk("z3sa0_pass", pass_a, 0);
`ifdef GATE_TT_FAULT_LOG_EN
    chk("z3sa0_ff", {ffv_a, ffg_a, ffvec_a, ffo_a}, 6'b1_10_00_0);
`endif

    // Abort in first SETTLE cycle of xnor vec 2 (cycle 22), inverted outputs
    fault_a = 2'd2;
    pulse_start_a();
    chk("abort_pass_cleared", pass_a, 0);
    for (int c = 2; c <= 22; c++) @(negedge clk);
    chk("abort_pre_err", err_a, 4);
    chk("abort_pre_cur", {gate_a, vec_a}, 4'b01_10);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_lanes", lanes_a(), 0);
    chk("abort_err", err_a, 4);
    chk("abort_pass", pass_a, 0);
`ifdef GATE_TT_FAULT_LOG_EN
    chk("abort_ff", {ffv_a, ffg_a, ffvec_a, ffo_a}, 6'b1_00_00_1);
`endif
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a) ndone++;
      @(negedge clk);
    end
    chk("abort_nodone", ndone, 0);

    // start and abort together in IDLE: stays idle, err not cleared
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("startabort_busy", busy_a, 0);
    chk("startabort_err", err_a, 4);

    // ERR_W=2 saturation, SETTLE_CYC=0
    fault_b = 2'd2;
    run_b("sat", 3, 0);

    // Async reset mid-run on B
    pulse_start_b();
    for (int c = 2; c <= 10; c++) @(negedge clk);
    chk("rstmid_pre_busy", busy_b, 1);
    chk("rstmid_pre_err", err_b, 3);
    rst_nb = 1'b0;
    #1;
    chk("rstmid_ctl", {busy_b, done_b, pass_b}, 0);
    chk("rstmid_err", err_b, 0);
    chk("rstmid_cur_lanes", (gate_b << 7) | (vec_b << 5) | lanes_b(), 0);
    @(negedge clk);
    rst_nb = 1'b1;
    fault_b = 2'd0;
    @(negedge clk);
    run_b("after_rst", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
